vib_alarm_gen_n: RTL and testbench
==================================

Name: vib_alarm_gen_n

Overview:
Parametrised next-generation vibration alarm generator for the vibrate-detect path. It supports CH_NUM channels and DW-bit peak data, with runtime-programmable threshold and hysteresis counts. Per channel it forms swing = max + min, qualifies it on each rising edge of the peak-valid strobe, and runs a debounced stable/alarm state machine. It sits between the per-channel peak detectors and the alarm/report logic.

Parameters:
CH_NUM, 4, number of channels
DW, 16, peak data and swing width
CNT_W, 8, hysteresis counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
detect_enable  in  1  0 = synchronous clear of all channel state
dat_max  in  CH_NUM*DW  channel c at bits [c*DW +: DW]
dat_min  in  CH_NUM*DW  same packing as dat_max
dat_max_en  in  CH_NUM  peak-valid level per channel; a rising edge is the evaluation event
high_threshold  in  DW  swing >= this counts as high
high_cnt  in  CNT_W  consecutive high events needed to raise the alarm
low_cnt  in  CNT_W  consecutive low events needed to clear the alarm
swing_range  out  CH_NUM*DW  combinational saturated max + min per channel
dat_alarm  out  CH_NUM  registered alarm per channel
alarm_any  out  1  registered OR of dat_alarm

Behaviour:
- Reset (rst=0, async): all states = STABLE; all counters, edge registers, dat_alarm and alarm_any = 0.
- Swing arithmetic:
  - swing = dat_max + dat_min at DW+1 bits.
  - If the carry is set, the result saturates to all-ones (2^DW-1).
  - swing_range is combinational from the inputs.
- Event detection:
  - dat_max_en passes through a 3-stage register chain r0→r1→r2.
  - event[c] = r1 & ~r2.
  - Level held high → exactly one event. Level low → none.
  - From the edge that samples max_en=1, the state/alarm update happens on the 3rd subsequent edge.
- Compare:
  - high = swing >= high_threshold, evaluated in the event cycle.
  - Threshold and count inputs are sampled only in event cycles.
- Effective counts: hc = max(high_cnt,1); lc = max(low_cnt,1).
- Per-channel FSM; states and counters change only on event cycles:
  - STABLE:
    - high → PEND_HI with hcnt=1.
    - If hc==1, go straight to ALARM instead.
  - PEND_HI:
    - high → hcnt+1; if hcnt+1 >= hc → ALARM, hcnt=0.
    - low → STABLE, hcnt=0.
  - ALARM:
    - low → PEND_LO with lcnt=1.
    - If lc==1, go straight to STABLE instead.
    - high → stay.
  - PEND_LO:
    - low → lcnt+1; if lcnt+1 >= lc → STABLE, lcnt=0.
    - high → ALARM, lcnt=0.
- Alarm outputs:
  - dat_alarm[c] is registered and equals 1 when the next state is ALARM or PEND_LO.
  - It therefore changes on the same edge as the state.
  - alarm_any is registered one cycle after dat_alarm.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Unused/illegal state encodings → STABLE with counters cleared on the next clock.
- detect_enable=0:
  - Synchronously clears states, counters, dat_alarm and alarm_any.
  - Edge registers keep running.
  - An event coinciding with detect_enable=0 is dropped.
- Channels are fully independent; simultaneous events on several channels are all processed in the same cycle.

Optional Feature:
Macro VIB_ALARM_IRQ_EN.
- Defined, adds three ports:
  - irq_status out CH_NUM: sticky. A bit sets on a 0→1 transition of dat_alarm[c].
  - irq_clr in CH_NUM: write-one-to-clear. If set and clear coincide in the same cycle, set wins.
  - irq out 1: registered OR of irq_status.
  - All three reset to 0 and are cleared by detect_enable=0.
- Undefined: these ports and their logic do not exist, and the remaining behaviour is identical.

Test Plan:
1. CH_NUM=4, thr=1500, hc=10, lc=5; ch0 max=800, min=800 (swing 1600), ten strobes → dat_alarm[0]=1 exactly at the 10th event's update edge; no alarm after 9. Ch1–3 stay 0.
2. ch0 in ALARM, swing=1000; four low events then one high → ch0 stays alarmed; five consecutive low events → dat_alarm[0]=0 on the 5th.
3. max=0xFFF0, min=0x0100 → swing_range=0xFFFF (saturated); with thr=0xFFFF this counts as high.
4. dat_max_en held high for 50 cycles → exactly one event; hc=0 behaves as hc=1, so the alarm is raised after a single high event.
5. rst pulsed low mid-PEND_HI, and separately detect_enable=0 while in ALARM → all outputs 0 immediately (async) / next edge (sync); next event restarts from STABLE.
6. With VIB_ALARM_IRQ_EN: alarm rise sets irq_status[2] and irq; irq_clr[2] asserted in the same cycle as a new rise → bit remains 1.

Source files
------------

// File: rtl/vib_alarm_gen_n.sv
// Per-channel vibration alarm generator: saturated swing, edge-qualified compare, debounced alarm FSM.
// Optional sticky interrupt block is compiled in when VIB_ALARM_IRQ_EN is defined.
module vib_alarm_gen_n #(
  parameter int CH_NUM = 4,
  parameter int DW     = 16,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 detect_enable,
  input  logic [CH_NUM*DW-1:0] dat_max,
  input  logic [CH_NUM*DW-1:0] dat_min,
  input  logic [CH_NUM-1:0]    dat_max_en,
  input  logic [DW-1:0]        high_threshold,
  input  logic [CNT_W-1:0]     high_cnt,
  input  logic [CNT_W-1:0]     low_cnt,
  output logic [CH_NUM*DW-1:0] swing_range,
  output logic [CH_NUM-1:0]    dat_alarm,
  output logic                 alarm_any
`ifdef VIB_ALARM_IRQ_EN
  ,
  input  logic [CH_NUM-1:0]    irq_clr,
  output logic [CH_NUM-1:0]    irq_status,
  output logic                 irq
`endif
);

  typedef enum logic [1:0] {STABLE, PEND_HI, ALARM, PEND_LO} state_t;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? {DW{1'b1}} : s[DW-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] c);
    return (c == '0) ? CNT_W'(1) : c;
  endfunction

  logic [CH_NUM-1:0] en_p0, en_p1, en_p2;
  logic [CH_NUM-1:0] evt_p1, high_p1;
  logic [CH_NUM-1:0] vld_p3, high_p3;
  logic [CNT_W-1:0]  hc_p3, lc_p3;

  state_t            state     [CH_NUM];
  state_t            state_nxt [CH_NUM];
  logic [CNT_W-1:0]  hcnt      [CH_NUM];
  logic [CNT_W-1:0]  hcnt_nxt  [CH_NUM];
  logic [CNT_W-1:0]  lcnt      [CH_NUM];
  logic [CNT_W-1:0]  lcnt_nxt  [CH_NUM];
  logic [CH_NUM-1:0] alarm_nxt;

  // Event cycle: swing compare against the live threshold
  always_comb begin
    swing_range = '0;
    evt_p1      = en_p1 & ~en_p2;
    high_p1     = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      swing_range[c*DW +: DW] = sat_add(dat_max[c*DW +: DW], dat_min[c*DW +: DW]);
      high_p1[c] = (swing_range[c*DW +: DW] >= high_threshold);
    end
  end

  // Update stage: debounce FSM acts on the event captured one cycle earlier
  always_comb begin
    alarm_nxt = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      state_nxt[c] = state[c];
      hcnt_nxt[c]  = hcnt[c];
      lcnt_nxt[c]  = lcnt[c];
      case (state[c])
        STABLE: if (vld_p3[c] && high_p3[c]) begin
          if (hc_p3 == CNT_W'(1)) state_nxt[c] = ALARM;
          else begin
            state_nxt[c] = PEND_HI;
            hcnt_nxt[c]  = CNT_W'(1);
          end
        end
        PEND_HI: if (vld_p3[c]) begin
          if (!high_p3[c]) begin
            state_nxt[c] = STABLE;
            hcnt_nxt[c]  = '0;
          end else if (sat_inc(hcnt[c]) >= hc_p3) begin
            state_nxt[c] = ALARM;
            hcnt_nxt[c]  = '0;
          end else hcnt_nxt[c] = sat_inc(hcnt[c]);
        end
        ALARM: if (vld_p3[c] && !high_p3[c]) begin
          if (lc_p3 == CNT_W'(1)) state_nxt[c] = STABLE;
          else begin
            state_nxt[c] = PEND_LO;
            lcnt_nxt[c]  = CNT_W'(1);
          end
        end
        PEND_LO: if (vld_p3[c]) begin
          if (high_p3[c]) begin
            state_nxt[c] = ALARM;
            lcnt_nxt[c]  = '0;
          end else if (sat_inc(lcnt[c]) >= lc_p3) begin
            state_nxt[c] = STABLE;
            lcnt_nxt[c]  = '0;
          end else lcnt_nxt[c] = sat_inc(lcnt[c]);
        end
        default: begin
          state_nxt[c] = STABLE;
          hcnt_nxt[c]  = '0;
          lcnt_nxt[c]  = '0;
        end
      endcase
      alarm_nxt[c] = (state_nxt[c] == ALARM) || (state_nxt[c] == PEND_LO);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_p0     <= '0;
      en_p1     <= '0;
      en_p2     <= '0;
      vld_p3    <= '0;
      high_p3   <= '0;
      hc_p3     <= CNT_W'(1);
      lc_p3     <= CNT_W'(1);
      dat_alarm <= '0;
      alarm_any <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) begin
        state[c] <= STABLE;
        hcnt[c]  <= '0;
        lcnt[c]  <= '0;
      end
`ifdef VIB_ALARM_IRQ_EN
      irq_status <= '0;
      irq        <= 1'b0;
`endif
    end else begin
      // Edge detector runs regardless of detect_enable so no stale edge survives a disable
      en_p0 <= dat_max_en;
      en_p1 <= en_p0;
      en_p2 <= en_p1;
      if (!detect_enable) begin
        vld_p3    <= '0;
        dat_alarm <= '0;
        alarm_any <= 1'b0;
        for (int c = 0; c < CH_NUM; c++) begin
          state[c] <= STABLE;
          hcnt[c]  <= '0;
          lcnt[c]  <= '0;
        end
`ifdef VIB_ALARM_IRQ_EN
        irq_status <= '0;
        irq        <= 1'b0;
`endif
      end else begin
        vld_p3 <= evt_p1;
        if (|evt_p1) begin
          high_p3 <= high_p1;
          hc_p3   <= at_least_one(high_cnt);
          lc_p3   <= at_least_one(low_cnt);
        end
        dat_alarm <= alarm_nxt;
        alarm_any <= |dat_alarm;
        for (int c = 0; c < CH_NUM; c++) begin
          state[c] <= state_nxt[c];
          hcnt[c]  <= hcnt_nxt[c];
          lcnt[c]  <= lcnt_nxt[c];
        end
`ifdef VIB_ALARM_IRQ_EN
        irq_status <= (irq_status & ~irq_clr) | (alarm_nxt & ~dat_alarm);
        irq        <= |irq_status;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vib_alarm_gen_n.sv
// Directed testbench for vib_alarm_gen_n; the irq scenario is compiled when VIB_ALARM_IRQ_EN is defined.
module tb_vib_alarm_gen_n;
  localparam int CH_NUM = 4;
  localparam int DW     = 16;
  localparam int CNT_W  = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 detect_enable;
  logic [CH_NUM*DW-1:0] dat_max, dat_min;
  logic [CH_NUM-1:0]    dat_max_en;
  logic [DW-1:0]        high_threshold;
  logic [CNT_W-1:0]     high_cnt, low_cnt;
  logic [CH_NUM*DW-1:0] swing_range;
  logic [CH_NUM-1:0]    dat_alarm;
  logic                 alarm_any;
`ifdef VIB_ALARM_IRQ_EN
  logic [CH_NUM-1:0]    irq_clr;
  logic [CH_NUM-1:0]    irq_status;
  logic                 irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vib_alarm_gen_n #(.CH_NUM(CH_NUM), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .detect_enable(detect_enable),
    .dat_max(dat_max), .dat_min(dat_min), .dat_max_en(dat_max_en),
    .high_threshold(high_threshold), .high_cnt(high_cnt), .low_cnt(low_cnt),
    .swing_range(swing_range), .dat_alarm(dat_alarm), .alarm_any(alarm_any)
`ifdef VIB_ALARM_IRQ_EN
    , .irq_clr(irq_clr), .irq_status(irq_status), .irq(irq)
`endif
  );

  task automatic set_ch(input int c, input logic [DW-1:0] mx, input logic [DW-1:0] mn);
    dat_max[c*DW +: DW] = mx;
    dat_min[c*DW +: DW] = mn;
  endtask

  // One-cycle strobe; returns 1 time unit after the update edge (3rd edge after sampling)
  task automatic strobe(input logic [CH_NUM-1:0] m);
    dat_max_en = m;
    @(posedge clk);
    #1 dat_max_en = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; detect_enable = 1'b1; dat_max = '0; dat_min = '0; dat_max_en = '0;
    high_threshold = 16'd1500; high_cnt = 8'd10; low_cnt = 8'd5;
`ifdef VIB_ALARM_IRQ_EN
    irq_clr = '0;
`endif
    #3;
    n_tests++; if (dat_alarm !== 4'b0000) begin n_fail++; $display("FAIL reset_alarm got=%b exp=0000", dat_alarm); end
    n_tests++; if (alarm_any !== 1'b0) begin n_fail++; $display("FAIL reset_any got=%b exp=0", alarm_any); end
`ifdef VIB_ALARM_IRQ_EN
    n_tests++; if (irq_status !== 4'b0000 || irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b/%b exp=0000/0", irq_status, irq); end
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_raise;
    set_ch(0, 16'd800, 16'd800);
    #1;
    n_tests++; if (swing_range[15:0] !== 16'd1600) begin n_fail++; $display("FAIL swing_ch0 got=%0d exp=1600", swing_range[15:0]); end
    for (int i = 0; i < 9; i++) strobe(4'b0001);
    n_tests++; if (dat_alarm !== 4'b0000) begin n_fail++; $display("FAIL raise_after9 got=%b exp=0000", dat_alarm); end
    dat_max_en = 4'b0001;
    @(posedge clk);
    #1 dat_max_en = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (dat_alarm !== 4'b0000) begin n_fail++; $display("FAIL raise_early got=%b exp=0000", dat_alarm); end
    @(posedge clk); #1;
    n_tests++; if (dat_alarm !== 4'b0001) begin n_fail++; $display("FAIL raise_after10 got=%b exp=0001", dat_alarm); end
    n_tests++; if (alarm_any !== 1'b0) begin n_fail++; $display("FAIL any_lag got=%b exp=0", alarm_any); end
    @(posedge clk); #1;
    n_tests++; if (alarm_any !== 1'b1) begin n_fail++; $display("FAIL any_set got=%b exp=1", alarm_any); end
  endtask

  task automatic test_clear;
    set_ch(0, 16'd500, 16'd500);
    for (int i = 0; i < 4; i++) strobe(4'b0001);
    n_tests++; if (dat_alarm !== 4'b0001) begin n_fail++; $display("FAIL low4 got=%b exp=0001", dat_alarm); end
    set_ch(0, 16'd800, 16'd800);
    strobe(4'b0001);
    n_tests++; if (dat_alarm !== 4'b0001) begin n_fail++; $display("FAIL high_back got=%b exp=0001", dat_alarm); end
    set_ch(0, 16'd500, 16'd500);
    for (int i = 0; i < 4; i++) strobe(4'b0001);
    n_tests++; if (dat_alarm !== 4'b0001) begin n_fail++; $display("FAIL low4b got=%b exp=0001", dat_alarm); end
    strobe(4'b0001);
    n_tests++; if (dat_alarm !== 4'b0000) begin n_fail++; $display("FAIL low5 got=%b exp=0000", dat_alarm); end
    @(posedge clk); #1;
    n_tests++; if (alarm_any !== 1'b0) begin n_fail++; $display("FAIL any_clr got=%b exp=0", alarm_any); end
  endtask

  task automatic test_saturate;
    set_ch(2, 16'hFFF0, 16'h0100);
    high_threshold = 16'hFFFF; high_cnt = 8'd1; low_cnt = 8'd1;
    #1;
    n_tests++; if (swing_range[47:32] !== 16'hFFFF) begin n_fail++; $display("FAIL sat_swing got=%h exp=ffff", swing_range[47:32]); end
    strobe(4'b0100);
    n_tests++; if (dat_alarm !== 4'b0100) begin n_fail++; $display("FAIL sat_high got=%b exp=0100", dat_alarm); end
    set_ch(2, 16'hFFF0, 16'h000E);
    #1;
    n_tests++; if (swing_range[47:32] !== 16'hFFFE) begin n_fail++; $display("FAIL unsat_swing got=%h exp=fffe", swing_range[47:32]); end
    strobe(4'b0100);
    n_tests++; if (dat_alarm !== 4'b0000) begin n_fail++; $display("FAIL below_thr got=%b exp=0000", dat_alarm); end
    high_threshold = 16'd1500; low_cnt = 8'd5;
    set_ch(2, 16'd0, 16'd0);
  endtask

  task automatic test_hold;
    set_ch(1, 16'd800, 16'd800);
    high_cnt = 8'd2;
    dat_max_en = 4'b0010;
    repeat (50) @(posedge clk);
    #1 dat_max_en = '0;
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (dat_alarm !== 4'b0000) begin n_fail++; $display("FAIL hold_one_event got=%b exp=0000", dat_alarm); end
    high_cnt = 8'd0;
    set_ch(3, 16'd800, 16'd800);
    strobe(4'b1000);
    n_tests++; if (dat_alarm !== 4'b1000) begin n_fail++; $display("FAIL hc0 got=%b exp=1000", dat_alarm); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    n_tests++; if (dat_alarm !== 4'b0000 || alarm_any !== 1'b0) begin n_fail++; $display("FAIL async_rst got=%b/%b exp=0000/0", dat_alarm, alarm_any); end
    @(posedge clk); #1 rst = 1'b1;
    high_cnt = 8'd2;
    strobe(4'b0010);
    n_tests++; if (dat_alarm !== 4'b0000) begin n_fail++; $display("FAIL rst_restart got=%b exp=0000", dat_alarm); end
  endtask

  task automatic test_detect_enable;
    set_ch(0, 16'd800, 16'd800);
    high_cnt = 8'd1;
    strobe(4'b0001);
    n_tests++; if (dat_alarm[0] !== 1'b1) begin n_fail++; $display("FAIL de_pre got=%b exp=1", dat_alarm[0]); end
    @(posedge clk); #1 detect_enable = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (dat_alarm !== 4'b0000 || alarm_any !== 1'b0) begin n_fail++; $display("FAIL de_clear got=%b/%b exp=0000/0", dat_alarm, alarm_any); end
    detect_enable = 1'b1;
    high_cnt = 8'd2;
    strobe(4'b0001);
    n_tests++; if (dat_alarm !== 4'b0000) begin n_fail++; $display("FAIL de_restart got=%b exp=0000", dat_alarm); end
    strobe(4'b0001);
    n_tests++; if (dat_alarm !== 4'b0001) begin n_fail++; $display("FAIL de_second got=%b exp=0001", dat_alarm); end
    high_cnt = 8'd1;
    detect_enable = 1'b0;
    strobe(4'b1000);
    detect_enable = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_tests++; if (dat_alarm !== 4'b0000) begin n_fail++; $display("FAIL de_drop got=%b exp=0000", dat_alarm); end
  endtask

`ifdef VIB_ALARM_IRQ_EN
  task automatic test_irq;
    high_cnt = 8'd1; low_cnt = 8'd1;
    set_ch(0, 16'd0, 16'd0); set_ch(1, 16'd0, 16'd0); set_ch(3, 16'd0, 16'd0);
    set_ch(2, 16'd800, 16'd800);
    strobe(4'b0100);
    n_tests++; if (irq_status !== 4'b0100) begin n_fail++; $display("FAIL irq_set got=%b exp=0100", irq_status); end
    @(posedge clk); #1;
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_out got=%b exp=1", irq); end
    irq_clr = 4'b0100;
    @(posedge clk); #1 irq_clr = '0;
    n_tests++; if (irq_status !== 4'b0000) begin n_fail++; $display("FAIL irq_w1c got=%b exp=0000", irq_status); end
    set_ch(2, 16'd500, 16'd500);
    strobe(4'b0100);
    set_ch(2, 16'd800, 16'd800);
    irq_clr = 4'b0100;
    strobe(4'b0100);
    n_tests++; if (irq_status[2] !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins got=%b exp=1", irq_status[2]); end
    irq_clr = '0;
  endtask
`endif

  initial begin
    fork
      begin
        test_reset;
        test_raise;
        test_clear;
        test_saturate;
        test_hold;
        test_reset_mid;
        test_detect_enable;
`ifdef VIB_ALARM_IRQ_EN
        test_irq;
`endif
      end
      begin
        #200000;
        n_tests++; n_fail++;
        $display("FAIL timeout got=running exp=done");
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
